// File: rtl/pipelined_decode_stage.sv
// Registered MIPS-subset decode stage with a per-register pending-write scoreboard.
// Optional feature: define ILLEGAL_OP_TRAP_EN to add the registered out_illegal flag.
module pipelined_decode_stage #(
  parameter int PC_W   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_ir,
  output logic [3:0]      out_alu_op,
  output logic [1:0]      out_shift_op,
  output logic [2:0]      out_condition,
  output logic [1:0]      out_b_in_sel,
  output logic [5:0]      out_ctl,
  output logic            out_wb_en,
  output logic [AW-1:0]   out_wb_addr,
  output logic            out_ovf_chk,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
`ifdef ILLEGAL_OP_TRAP_EN
  output logic            out_illegal,
`endif
  output logic            stall_raw
);

  localparam int PEND_MAX = (1 << PEND_W) - 1;

  logic [5:0]    op, funct;
  logic [AW-1:0] rs_a, rt_a, rd_a, dst_a;

  logic [3:0] d_alu;
  logic [1:0] d_shift, d_bsel;
  logic [2:0] d_cond;
  logic       d_jump, d_ext, d_rdsel, d_rtsel, d_ashift, d_samt;
  logic       d_writes, d_ovf, use_rs, use_rt;
  logic       d_wb_en;
  logic [AW-1:0] d_wb_addr;
`ifdef ILLEGAL_OP_TRAP_EN
  logic       d_illegal;
`endif

  logic [PEND_W-1:0] pend     [NREG];
  logic [PEND_W-1:0] pend_nxt [NREG];
  logic hazard, issue;
  int   cnt;

  assign op    = in_ir[31:26];
  assign funct = in_ir[5:0];
  assign rs_a  = in_ir[21 +: AW];
  assign rt_a  = in_ir[16 +: AW];
  assign rd_a  = in_ir[11 +: AW];

  always_comb begin
    d_alu    = '0;
    d_shift  = '0;
    d_cond   = '0;
    d_bsel   = '0;
    d_jump   = 1'b0;
    d_ext    = 1'b0;
    d_rdsel  = 1'b0;
    d_rtsel  = 1'b0;
    d_ashift = 1'b0;
    d_samt   = 1'b0;
    d_writes = 1'b0;
    d_ovf    = 1'b0;
    use_rs   = 1'b1;
    use_rt   = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
    d_illegal = 1'b0;
`endif
    case (op)
      6'b000000: begin
        use_rt   = 1'b1;
        d_rdsel  = 1'b1;
        d_writes = 1'b1;
        case (funct)
          6'b000000: d_ashift = 1'b1;
          6'b000010: begin d_ashift = 1'b1; d_shift = {in_ir[21], 1'b1}; end
          6'b000011: begin d_ashift = 1'b1; d_shift = 2'b10; end
          6'b000100: begin d_ashift = 1'b1; d_samt = 1'b1; end
          6'b000110: begin d_ashift = 1'b1; d_samt = 1'b1; d_shift = {in_ir[6], 1'b1}; end
          6'b000111: begin d_ashift = 1'b1; d_samt = 1'b1; d_shift = 2'b10; end
          6'b100000: begin d_alu = 4'b1110; d_ovf = 1'b1; end
          6'b100001: d_alu = 4'b0000;
          6'b100010: begin d_alu = 4'b1111; d_ovf = 1'b1; end
          6'b100011: d_alu = 4'b0001;
          6'b100100: d_alu = 4'b0100;
          6'b100101: d_alu = 4'b0110;
          6'b100110: d_alu = 4'b1001;
          6'b100111: d_alu = 4'b1000;
          6'b101010: d_alu = 4'b0101;
          6'b101011: d_alu = 4'b0111;
          6'b110010, 6'b110011: begin d_alu = 4'b0001; d_writes = 1'b0; end
          default: ;
        endcase
      end
      // REGIMM compares rs against $0, hence the forced rt address
      6'b000001: begin
        d_alu = 4'b0001; d_cond = {!in_ir[16], 1'b1, in_ir[16]};
        d_ext = 1'b1; d_rtsel = 1'b1;
      end
      6'b000010, 6'b000011: begin d_jump = 1'b1; use_rs = 1'b0; end
      6'b000100: begin d_alu = 4'b0001; d_cond = 3'b001; d_ext = 1'b1; use_rt = 1'b1; end
      6'b000101: begin d_alu = 4'b0001; d_cond = 3'b010; d_ext = 1'b1; use_rt = 1'b1; end
      6'b000110: begin d_alu = 4'b0001; d_cond = 3'b101; d_ext = 1'b1; d_rtsel = 1'b1; end
      6'b000111: begin d_alu = 4'b0001; d_cond = 3'b100; d_ext = 1'b1; d_rtsel = 1'b1; end
      6'b001000: begin d_alu = 4'b1110; d_ovf = 1'b1; d_bsel = 2'b01; d_ext = 1'b1; d_writes = 1'b1; end
      6'b001001: begin d_alu = 4'b0000; d_bsel = 2'b01; d_ext = 1'b1; d_writes = 1'b1; end
      6'b001010: begin d_alu = 4'b0101; d_bsel = 2'b01; d_ext = 1'b1; d_writes = 1'b1; end
      6'b001011: begin d_alu = 4'b0111; d_bsel = 2'b01; d_ext = 1'b1; d_writes = 1'b1; end
      6'b001100: begin d_alu = 4'b0100; d_bsel = 2'b01; d_writes = 1'b1; end
      6'b001101: begin d_alu = 4'b0110; d_bsel = 2'b01; d_writes = 1'b1; end
      6'b001110: begin d_alu = 4'b1001; d_bsel = 2'b01; d_writes = 1'b1; end
      6'b001111: begin d_bsel = 2'b10; d_writes = 1'b1; use_rs = 1'b0; end
      6'b011100: begin d_alu = {3'b001, funct[0]}; d_rdsel = 1'b1; d_writes = 1'b1; end
      6'b011111: begin d_alu = {3'b101, in_ir[6]}; d_rdsel = 1'b1; d_writes = 1'b1; end
      default: begin
`ifdef ILLEGAL_OP_TRAP_EN
        d_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign dst_a     = d_rdsel ? rd_a : rt_a;
  assign d_wb_en   = d_writes && (dst_a != '0);
  assign d_wb_addr = d_wb_en ? dst_a : '0;

  assign hazard = (use_rs && (pend[rs_a] != '0)) ||
                  (use_rt && (pend[rt_a] != '0)) ||
                  (d_wb_en && (pend[dst_a] == PEND_W'(PEND_MAX)));

  assign in_ready  = !hazard && (!out_valid || out_ready || flush);
  assign issue     = in_valid && in_ready;
  assign stall_raw = in_valid && hazard;

  // Increment, flush and writeback combine arithmetically so coincident events net out
  always_comb begin
    cnt = 0;
    for (int i = 0; i < NREG; i++) begin
      cnt = int'(pend[i]);
      if (issue && d_wb_en && (int'(d_wb_addr) == i)) cnt = cnt + 1;
      if (flush && out_valid && out_wb_en && (int'(out_wb_addr) == i)) cnt = cnt - 1;
      if (wb_valid && (int'(wb_addr) == i)) cnt = cnt - 1;
      if (cnt < 0) cnt = 0;
      if (cnt > PEND_MAX) cnt = PEND_MAX;
      if (i == 0) cnt = 0;
      pend_nxt[i] = PEND_W'(cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      pend <= pend_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_ir        <= '0;
      out_alu_op    <= '0;
      out_shift_op  <= '0;
      out_condition <= '0;
      out_b_in_sel  <= '0;
      out_ctl       <= '0;
      out_wb_en     <= 1'b0;
      out_wb_addr   <= '0;
      out_ovf_chk   <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      out_illegal   <= 1'b0;
`endif
    end else if (issue) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_ir        <= in_ir;
      out_alu_op    <= d_alu;
      out_shift_op  <= d_shift;
      out_condition <= d_cond;
      out_b_in_sel  <= d_bsel;
      out_ctl       <= {d_jump, d_ext, d_rdsel, d_rtsel, d_ashift, d_samt};
      out_wb_en     <= d_wb_en;
      out_wb_addr   <= d_wb_addr;
      out_ovf_chk   <= d_ovf;
`ifdef ILLEGAL_OP_TRAP_EN
      out_illegal   <= d_illegal;
`endif
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Bench for pipelined_decode_stage: directed scenarios followed by random traffic,
// checked against an instruction-table decode model and an integer scoreboard model.
module tb_pipelined_decode_stage;
  localparam int PC_W   = 32;
  localparam int NREG   = 32;
  localparam int PEND_W = 2;
  localparam int AW     = $clog2(NREG);
  localparam int PMAX   = (1 << PEND_W) - 1;

  localparam logic [31:0] OP  = 32'hFC00_0000;
  localparam logic [31:0] OPF = 32'hFC00_003F;
  localparam logic [31:0] B21 = 32'h0020_0000;
  localparam logic [31:0] B16 = 32'h0001_0000;
  localparam logic [31:0] B6  = 32'h0000_0040;
  localparam logic [31:0] B0  = 32'h0000_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_ir, out_ir;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [3:0]      out_alu_op;
  logic [1:0]      out_shift_op, out_b_in_sel;
  logic [2:0]      out_condition;
  logic [5:0]      out_ctl;
  logic            out_wb_en, out_ovf_chk, wb_valid, flush, stall_raw;
  logic [AW-1:0]   out_wb_addr, wb_addr;
`ifdef ILLEGAL_OP_TRAP_EN
  logic            out_illegal;
`endif

  pipelined_decode_stage #(.PC_W(PC_W), .NREG(NREG), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_ir(out_ir), .out_alu_op(out_alu_op), .out_shift_op(out_shift_op),
    .out_condition(out_condition), .out_b_in_sel(out_b_in_sel), .out_ctl(out_ctl),
    .out_wb_en(out_wb_en), .out_wb_addr(out_wb_addr), .out_ovf_chk(out_ovf_chk),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
`ifdef ILLEGAL_OP_TRAP_EN
    .out_illegal(out_illegal),
`endif
    .stall_raw(stall_raw)
  );

  typedef struct {
    string       name;
    logic [31:0] mask, val;
    logic [3:0]  alu;
    logic [1:0]  sh;
    logic [2:0]  cond;
    logic [1:0]  bsel;
    logic [5:0]  ctl;
    bit          writes, dst_rd, use_rs, use_rt, ovf, ill;
  } ent_t;

  ent_t tbl[$];
  int   pend_m [NREG];
  int   cur_idx;
  int   checks = 0, passed = 0, fails = 0;

  bit              m_valid, m_known, m_wb_en, m_ovf, m_ill;
  logic [PC_W-1:0] m_pc;
  logic [31:0]     m_ir;
  logic [3:0]      m_alu;
  logic [1:0]      m_sh, m_bsel;
  logic [2:0]      m_cond;
  logic [5:0]      m_ctl;
  int              m_wb_addr;

  function automatic void add(string n, logic [31:0] m, logic [31:0] v, logic [3:0] a,
                              logic [1:0] s, logic [2:0] c, logic [1:0] b, logic [5:0] ct,
                              bit w, bit rd, bit urs, bit urt, bit ov, bit il);
    ent_t e;
    e.name = n; e.mask = m; e.val = v; e.alu = a; e.sh = s; e.cond = c; e.bsel = b;
    e.ctl = ct; e.writes = w; e.dst_rd = rd; e.use_rs = urs; e.use_rt = urt;
    e.ovf = ov; e.ill = il;
    tbl.push_back(e);
  endfunction

  function automatic int ix(string n);
    foreach (tbl[i]) if (tbl[i].name == n) return i;
    return 0;
  endfunction

  function automatic logic [31:0] mk(int idx, int rs, int rt, int rd);
    logic [31:0] ir;
    ir = $urandom;
    ir[25:21] = 5'(rs);
    ir[20:16] = 5'(rt);
    ir[15:11] = 5'(rd);
    return (ir & ~tbl[idx].mask) | tbl[idx].val;
  endfunction

  function automatic int dest_of(int idx, logic [31:0] ir);
    if (!tbl[idx].writes) return 0;
    return tbl[idx].dst_rd ? int'(ir[15:11]) : int'(ir[20:16]);
  endfunction

  function automatic bit blocked(int idx, logic [31:0] ir);
    int d;
    d = dest_of(idx, ir);
    if (tbl[idx].use_rs && pend_m[ir[25:21]] != 0) return 1'b1;
    if (tbl[idx].use_rt && pend_m[ir[20:16]] != 0) return 1'b1;
    if (d != 0 && pend_m[d] == PMAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [AW-1:0] pick_wb();
    int r;
    r = int'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1)
      for (int i = 1; i < 8; i++) if (pend_m[(r + i) % 8] != 0) return AW'((r + i) % 8);
    return AW'(r);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(bit v, int idx, logic [31:0] ir);
    in_valid = v;
    cur_idx  = idx;
    in_ir    = ir;
    in_pc    = PC_W'($urandom);
  endtask

  // One clock: handshake checks before the edge, model update at the edge, outputs after it
  task automatic tick();
    bit hz, rdy, iss;
    int d, v;
    int delta [NREG];
    #1;
    hz  = blocked(cur_idx, in_ir);
    rdy = !hz && (!m_valid || out_ready || flush);
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(rdy));
      chk("stall_raw", 64'(stall_raw), 64'(in_valid && hz));
    end
    iss = in_valid && rdy;
    @(posedge clk);
    if (rst) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      m_valid = 0; m_known = 1; m_pc = '0; m_ir = '0; m_alu = '0; m_sh = '0;
      m_cond = '0; m_bsel = '0; m_ctl = '0; m_wb_en = 0; m_wb_addr = 0; m_ovf = 0; m_ill = 0;
    end else begin
      foreach (delta[i]) delta[i] = 0;
      d = dest_of(cur_idx, in_ir);
      if (iss && d != 0) delta[d]++;
      if (flush && m_valid && m_wb_en) delta[m_wb_addr]--;
      if (wb_valid && wb_addr != 0) delta[wb_addr]--;
      for (int i = 0; i < NREG; i++) begin
        v = pend_m[i] + delta[i];
        pend_m[i] = (v < 0) ? 0 : (v > PMAX) ? PMAX : v;
      end
      if (iss) begin
        m_valid = 1; m_known = 1; m_pc = in_pc; m_ir = in_ir;
        m_alu = tbl[cur_idx].alu; m_sh = tbl[cur_idx].sh; m_cond = tbl[cur_idx].cond;
        m_bsel = tbl[cur_idx].bsel; m_ctl = tbl[cur_idx].ctl; m_ovf = tbl[cur_idx].ovf;
        m_ill = tbl[cur_idx].ill; m_wb_en = (d != 0); m_wb_addr = d;
      end else if (flush || out_ready) begin
        if (m_valid) m_known = 0;
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_known) begin
      chk("out_pc", 64'(out_pc), 64'(m_pc));
      chk("out_ir", 64'(out_ir), 64'(m_ir));
      chk("out_alu_op", 64'(out_alu_op), 64'(m_alu));
      chk("out_shift_op", 64'(out_shift_op), 64'(m_sh));
      chk("out_condition", 64'(out_condition), 64'(m_cond));
      chk("out_b_in_sel", 64'(out_b_in_sel), 64'(m_bsel));
      chk("out_ctl", 64'(out_ctl), 64'(m_ctl));
      chk("out_wb_en", 64'(out_wb_en), 64'(m_wb_en));
      chk("out_wb_addr", 64'(out_wb_addr), 64'(m_wb_addr));
      chk("out_ovf_chk", 64'(out_ovf_chk), 64'(m_ovf));
`ifdef ILLEGAL_OP_TRAP_EN
      chk("out_illegal", 64'(out_illegal), 64'(m_ill));
`endif
    end
  endtask

  initial begin
    logic [31:0] addi_ir, ori_ir;
    int k;
    //  name     mask       value        alu      sh     cond    bsel   ctl        w rd rs rt ov il
    add("SLL",   OPF,       32'h00000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b001010, 1, 1, 1, 1, 0, 0);
    add("SRL",   OPF | B21, 32'h00000002, 4'b0000, 2'b01, 3'b000, 2'b00, 6'b001010, 1, 1, 1, 1, 0, 0);
    add("ROTR",  OPF | B21, 32'h00200002, 4'b0000, 2'b11, 3'b000, 2'b00, 6'b001010, 1, 1, 1, 1, 0, 0);
    add("SRA",   OPF,       32'h00000003, 4'b0000, 2'b10, 3'b000, 2'b00, 6'b001010, 1, 1, 1, 1, 0, 0);
    add("SLLV",  OPF,       32'h00000004, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b001011, 1, 1, 1, 1, 0, 0);
    add("SRLV",  OPF | B6,  32'h00000006, 4'b0000, 2'b01, 3'b000, 2'b00, 6'b001011, 1, 1, 1, 1, 0, 0);
    add("ROTRV", OPF | B6,  32'h00000046, 4'b0000, 2'b11, 3'b000, 2'b00, 6'b001011, 1, 1, 1, 1, 0, 0);
    add("SRAV",  OPF,       32'h00000007, 4'b0000, 2'b10, 3'b000, 2'b00, 6'b001011, 1, 1, 1, 1, 0, 0);
    add("ADD",   OPF,       32'h00000020, 4'b1110, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 1, 0);
    add("ADDU",  OPF,       32'h00000021, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("SUB",   OPF,       32'h00000022, 4'b1111, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 1, 0);
    add("SUBU",  OPF,       32'h00000023, 4'b0001, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("AND",   OPF,       32'h00000024, 4'b0100, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("OR",    OPF,       32'h00000025, 4'b0110, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("XOR",   OPF,       32'h00000026, 4'b1001, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("NOR",   OPF,       32'h00000027, 4'b1000, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("SLT",   OPF,       32'h0000002A, 4'b0101, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("SLTU",  OPF,       32'h0000002B, 4'b0111, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 1, 0, 0);
    add("TLT",   OPF,       32'h00000032, 4'b0001, 2'b00, 3'b000, 2'b00, 6'b001000, 0, 1, 1, 1, 0, 0);
    add("TLTU",  OPF,       32'h00000033, 4'b0001, 2'b00, 3'b000, 2'b00, 6'b001000, 0, 1, 1, 1, 0, 0);
    add("BLTZ",  OP | B16,  32'h04000000, 4'b0001, 2'b00, 3'b110, 2'b00, 6'b010100, 0, 0, 1, 0, 0, 0);
    add("BGEZ",  OP | B16,  32'h04010000, 4'b0001, 2'b00, 3'b011, 2'b00, 6'b010100, 0, 0, 1, 0, 0, 0);
    add("J",     OP,        32'h08000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b100000, 0, 0, 0, 0, 0, 0);
    add("JAL",   OP,        32'h0C000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b100000, 0, 0, 0, 0, 0, 0);
    add("BEQ",   OP,        32'h10000000, 4'b0001, 2'b00, 3'b001, 2'b00, 6'b010000, 0, 0, 1, 1, 0, 0);
    add("BNE",   OP,        32'h14000000, 4'b0001, 2'b00, 3'b010, 2'b00, 6'b010000, 0, 0, 1, 1, 0, 0);
    add("BLEZ",  OP,        32'h18000000, 4'b0001, 2'b00, 3'b101, 2'b00, 6'b010100, 0, 0, 1, 0, 0, 0);
    add("BGTZ",  OP,        32'h1C000000, 4'b0001, 2'b00, 3'b100, 2'b00, 6'b010100, 0, 0, 1, 0, 0, 0);
    add("ADDI",  OP,        32'h20000000, 4'b1110, 2'b00, 3'b000, 2'b01, 6'b010000, 1, 0, 1, 0, 1, 0);
    add("ADDIU", OP,        32'h24000000, 4'b0000, 2'b00, 3'b000, 2'b01, 6'b010000, 1, 0, 1, 0, 0, 0);
    add("SLTI",  OP,        32'h28000000, 4'b0101, 2'b00, 3'b000, 2'b01, 6'b010000, 1, 0, 1, 0, 0, 0);
    add("SLTIU", OP,        32'h2C000000, 4'b0111, 2'b00, 3'b000, 2'b01, 6'b010000, 1, 0, 1, 0, 0, 0);
    add("ANDI",  OP,        32'h30000000, 4'b0100, 2'b00, 3'b000, 2'b01, 6'b000000, 1, 0, 1, 0, 0, 0);
    add("ORI",   OP,        32'h34000000, 4'b0110, 2'b00, 3'b000, 2'b01, 6'b000000, 1, 0, 1, 0, 0, 0);
    add("XORI",  OP,        32'h38000000, 4'b1001, 2'b00, 3'b000, 2'b01, 6'b000000, 1, 0, 1, 0, 0, 0);
    add("LUI",   OP,        32'h3C000000, 4'b0000, 2'b00, 3'b000, 2'b10, 6'b000000, 1, 0, 0, 0, 0, 0);
    add("CLZ",   OP | B0,   32'h70000000, 4'b0010, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 0, 0, 0);
    add("CLO",   OP | B0,   32'h70000001, 4'b0011, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 0, 0, 0);
    add("SEB",   OP | B6,   32'h7C000000, 4'b1010, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 0, 0, 0);
    add("SEH",   OP | B6,   32'h7C000040, 4'b1011, 2'b00, 3'b000, 2'b00, 6'b001000, 1, 1, 1, 0, 0, 0);
    add("LW",    OP,        32'h8C000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b000000, 0, 0, 1, 0, 0, 1);
    add("COP0",  OP,        32'h40000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b000000, 0, 0, 1, 0, 0, 1);
    add("OP3F",  OP,        32'hFC000000, 4'b0000, 2'b00, 3'b000, 2'b00, 6'b000000, 0, 0, 1, 0, 0, 1);

    rst = 1; out_ready = 0; flush = 0; wb_valid = 0; wb_addr = '0;
    set_in(0, ix("SLL"), 32'h0);
    m_valid = 0; m_known = 0;
    foreach (pend_m[i]) pend_m[i] = 0;
    @(posedge clk); #1;
    tick();
    rst = 0;
    tick();

    // ADD $3,$1,$2 issues with one cycle of latency
    out_ready = 1;
    set_in(1, ix("ADD"), mk(ix("ADD"), 1, 2, 3));
    tick();
    chk("add_valid", 64'(out_valid), 64'(1));
    chk("add_alu", 64'(out_alu_op), 64'(4'b1110));
    chk("add_wb_addr", 64'(out_wb_addr), 64'(3));
    chk("add_ovf", 64'(out_ovf_chk), 64'(1));

    // ADDI $4,$3 must wait for $3 to retire
    addi_ir = mk(ix("ADDI"), 3, 4, 0);
    set_in(1, ix("ADDI"), addi_ir);
    #1;
    chk("raw_stall", 64'(stall_raw), 64'(1));
    chk("raw_ready", 64'(in_ready), 64'(0));
    tick();
    wb_valid = 1; wb_addr = AW'(3);
    tick();
    wb_valid = 0;
    tick();
    chk("addi_issued_ir", 64'(out_ir), 64'(addi_ir));

    // Held output blocks the next instruction until a flush frees the slot
    out_ready = 0;
    ori_ir = mk(ix("ORI"), 0, 6, 0);
    set_in(1, ix("ORI"), ori_ir);
    #1;
    chk("hold_ready", 64'(in_ready), 64'(0));
    tick();
    chk("hold_ir", 64'(out_ir), 64'(addi_ir));
    flush = 1;
    tick();
    flush = 0;
    chk("flush_load_ir", 64'(out_ir), 64'(ori_ir));
    out_ready = 1;
    set_in(1, ix("ADD"), mk(ix("ADD"), 4, 0, 7));
    #1;
    chk("flush_freed_r4", 64'(stall_raw), 64'(0));
    tick();

    // Counter saturation on $5
    set_in(1, ix("LUI"), mk(ix("LUI"), 0, 5, 0));
    tick(); tick(); tick();
    #1;
    chk("sat_stall", 64'(stall_raw), 64'(1));
    tick();
    wb_valid = 1; wb_addr = AW'(5);
    tick();
    tick();
    wb_valid = 0;
    tick();
    #1;
    chk("sat_stall_again", 64'(stall_raw), 64'(1));
    tick();

    // REGIMM branches
    set_in(1, ix("BGEZ"), mk(ix("BGEZ"), 1, 1, 0));
    tick();
    chk("bgez_cond", 64'(out_condition), 64'(3'b011));
    chk("bgez_rtsel", 64'(out_ctl[2]), 64'(1));
    chk("bgez_wb_en", 64'(out_wb_en), 64'(0));
    set_in(1, ix("BLTZ"), mk(ix("BLTZ"), 1, 0, 0));
    tick();
    chk("bltz_cond", 64'(out_condition), 64'(3'b110));

    // Reset in the middle of a stall clears the scoreboard
    out_ready = 0;
    set_in(1, ix("LUI"), mk(ix("LUI"), 0, 5, 0));
    tick();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_valid", 64'(out_valid), 64'(0));
    tick();

    for (int n = 0; n < 600; n++) begin
      k = int'($urandom_range(0, tbl.size() - 1));
      set_in($urandom_range(0, 9) < 7, k,
             mk(k, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7))));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_addr   = pick_wb();
      rst       = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
